// File: rtl/dispatch_lane_sequencer.sv
// Round-robin picks one dispatch stream, locks to it, and streams its live thread batches as lane-wide packets.
// One register stage to the output; loads only when the output slot is empty or being accepted, holding steady while stalled.
module dispatch_lane_sequencer #(
   parameter  int ISSUE_WIDTH = 4,
   parameter  int NUM_THREADS = 8,
   parameter  int NUM_LANES   = 4,
   parameter  int XLEN        = 32,
   parameter  int HDRW        = 64,
   localparam int BATCHES     = NUM_THREADS / NUM_LANES,
   localparam int PID_W       = (BATCHES > 1) ? $clog2(BATCHES) : 1,
   localparam int ISW_W       = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [ISSUE_WIDTH-1:0]              in_valid,
   output logic [ISSUE_WIDTH-1:0]              in_ready,
   input  logic [ISSUE_WIDTH*NUM_THREADS-1:0]  in_tmask,
   input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs1_data,
   input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs2_data,
   input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs3_data,
   input  logic [ISSUE_WIDTH*HDRW-1:0]         in_header,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NUM_LANES-1:0]                out_tmask,
   output logic [NUM_LANES*XLEN-1:0]           out_rs1_data,
   output logic [NUM_LANES*XLEN-1:0]           out_rs2_data,
   output logic [NUM_LANES*XLEN-1:0]           out_rs3_data,
   output logic [HDRW-1:0]                     out_header,
   output logic [ISW_W-1:0]                    out_isw,
   output logic [PID_W-1:0]                    out_pid,
   output logic                                out_sop,
   output logic                                out_eop,
   output logic [31:0]                         stall_count
);

   localparam int LW = NUM_LANES * XLEN;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t               state_q;
   logic [ISW_W-1:0]     rr_ptr_q, rr_ptr_d, lock_isw_q;
   logic [PID_W-1:0]     cur_pid_q;
   logic [31:0]          stall_q, stall_d;

   logic                 out_valid_q, out_sop_q, out_eop_q;
   logic [NUM_LANES-1:0] out_tmask_q;
   logic [LW-1:0]        out_rs1_q, out_rs2_q, out_rs3_q;
   logic [HDRW-1:0]      out_header_q;
   logic [ISW_W-1:0]     out_isw_q;
   logic [PID_W-1:0]     out_pid_q;

   logic                 advance, win_vld, sel_vld, has_next;
   logic [ISW_W-1:0]     win_isw, sel_isw;
   logic [NUM_THREADS-1:0] sel_tmask;
   logic [BATCHES-1:0]   live;
   logic [PID_W-1:0]     first_pid, emit_pid, next_pid;
   logic [LW-1:0]        lane_rs1, lane_rs2, lane_rs3;
   logic [HDRW-1:0]      sel_header;
   int                   base;

   assign advance = !out_valid_q || out_ready;

   // Descending scan so the stream closest to rr_ptr_q is the last, winning assignment.
   always_comb begin
      win_vld = 1'b0;
      win_isw = '0;
      for (int i = ISSUE_WIDTH - 1; i >= 0; i--) begin
         if (in_valid[(int'(rr_ptr_q) + i) % ISSUE_WIDTH]) begin
            win_vld = 1'b1;
            win_isw = ISW_W'((int'(rr_ptr_q) + i) % ISSUE_WIDTH);
         end
      end
   end

   always_comb begin
      sel_isw   = (state_q == S_BUSY) ? lock_isw_q : win_isw;
      sel_vld   = (state_q == S_BUSY) || win_vld;
      sel_tmask = in_tmask[int'(sel_isw)*NUM_THREADS +: NUM_THREADS];
      for (int b = 0; b < BATCHES; b++) begin
         live[b] = |sel_tmask[b*NUM_LANES +: NUM_LANES];
      end
      // An all-zero mask falls through to batch 0 with no successor: a single empty packet.
      first_pid = '0;
      for (int b = BATCHES - 1; b >= 0; b--) begin
         if (live[b]) first_pid = PID_W'(b);
      end
      emit_pid = (state_q == S_BUSY) ? cur_pid_q : first_pid;
      has_next = 1'b0;
      next_pid = '0;
      for (int b = BATCHES - 1; b >= 0; b--) begin
         if (live[b] && (b > int'(emit_pid))) begin
            has_next = 1'b1;
            next_pid = PID_W'(b);
         end
      end
      base       = (int'(sel_isw)*NUM_THREADS + int'(emit_pid)*NUM_LANES) * XLEN;
      lane_rs1   = in_rs1_data[base +: LW];
      lane_rs2   = in_rs2_data[base +: LW];
      lane_rs3   = in_rs3_data[base +: LW];
      sel_header = in_header[int'(sel_isw)*HDRW +: HDRW];
      rr_ptr_d   = ISW_W'((int'(sel_isw) + 1) % ISSUE_WIDTH);
      stall_d    = (out_valid_q && !out_ready) ? stall_q + 32'd1 : stall_q;
   end

   always_comb begin
      in_ready = '0;
      if (advance && sel_vld && !has_next) in_ready[sel_isw] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         lock_isw_q   <= '0;
         cur_pid_q    <= '0;
         stall_q      <= '0;
         out_valid_q  <= 1'b0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         out_tmask_q  <= '0;
         out_rs1_q    <= '0;
         out_rs2_q    <= '0;
         out_rs3_q    <= '0;
         out_header_q <= '0;
         out_isw_q    <= '0;
         out_pid_q    <= '0;
      end else begin
         stall_q <= stall_d;
         if (advance) begin
            out_valid_q <= sel_vld;
            if (sel_vld) begin
               out_tmask_q  <= sel_tmask[int'(emit_pid)*NUM_LANES +: NUM_LANES];
               out_rs1_q    <= lane_rs1;
               out_rs2_q    <= lane_rs2;
               out_rs3_q    <= lane_rs3;
               out_header_q <= sel_header;
               out_isw_q    <= sel_isw;
               out_pid_q    <= emit_pid;
               out_sop_q    <= (state_q == S_IDLE);
               out_eop_q    <= !has_next;
               if (!has_next) begin
                  state_q  <= S_IDLE;
                  rr_ptr_q <= rr_ptr_d;
               end else begin
                  state_q    <= S_BUSY;
                  lock_isw_q <= sel_isw;
                  cur_pid_q  <= next_pid;
               end
            end
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_tmask    = out_tmask_q;
   assign out_rs1_data = out_rs1_q;
   assign out_rs2_data = out_rs2_q;
   assign out_rs3_data = out_rs3_q;
   assign out_header   = out_header_q;
   assign out_isw      = out_isw_q;
   assign out_pid      = out_pid_q;
   assign out_sop      = out_sop_q;
   assign out_eop      = out_eop_q;
   assign stall_count  = stall_q;

endmodule

// File: tb/tb_dispatch_lane_sequencer.sv
// Directed bench: vector table for single-stream packetization and stalls,
// plus hand sequences for round-robin alternation and mid-instruction reset.
module tb_dispatch_lane_sequencer;
   localparam int IW = 4;
   localparam int NT = 8;
   localparam int NL = 4;
   localparam int XL = 32;
   localparam int HW = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  reset;
   logic [IW-1:0]         in_valid, in_ready;
   logic [IW*NT-1:0]      in_tmask;
   logic [IW*NT*XL-1:0]   in_rs1_data, in_rs2_data, in_rs3_data;
   logic [IW*HW-1:0]      in_header;
   logic                  out_valid, out_ready, out_sop, out_eop;
   logic [NL-1:0]         out_tmask;
   logic [NL*XL-1:0]      out_rs1_data, out_rs2_data, out_rs3_data;
   logic [HW-1:0]         out_header;
   logic [1:0]            out_isw;
   logic [0:0]            out_pid;
   logic [31:0]           stall_count;

   dispatch_lane_sequencer dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_tmask(in_tmask),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
      .in_header(in_header),
      .out_valid(out_valid), .out_ready(out_ready), .out_tmask(out_tmask),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
      .out_header(out_header), .out_isw(out_isw), .out_pid(out_pid),
      .out_sop(out_sop), .out_eop(out_eop), .stall_count(stall_count)
   );

   int nvec = 0;
   int nmis = 0;

   function automatic logic [31:0] dat(input int k, input int s, input int t);
      return 32'((k << 24) | (s << 16) | (t << 4) | 3);
   endfunction

   function automatic logic [63:0] hdr_of(input int s);
      return {32'hC0DE_0000, 32'(s * 7 + 1)};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_pkt(input int isw, input int pid, input logic [3:0] tm,
                          input logic sop, input logic eop);
      logic [127:0] e1, e2, e3;
      e1 = '0; e2 = '0; e3 = '0;
      for (int l = 0; l < NL; l++) begin
         e1[l*XL +: XL] = dat(1, isw, pid*NL + l);
         e2[l*XL +: XL] = dat(2, isw, pid*NL + l);
         e3[l*XL +: XL] = dat(3, isw, pid*NL + l);
      end
      chk("out_valid", 128'(out_valid), 128'(1));
      chk("out_tmask", 128'(out_tmask), 128'(tm));
      chk("out_pid", 128'(out_pid), 128'(pid));
      chk("sop_eop", 128'({out_sop, out_eop}), 128'({sop, eop}));
      chk("out_isw", 128'(out_isw), 128'(isw));
      chk("out_header", 128'(out_header), 128'(hdr_of(isw)));
      chk("out_rs1", out_rs1_data, e1);
      chk("out_rs2", out_rs2_data, e2);
      chk("out_rs3", out_rs3_data, e3);
   endtask

   typedef struct {
      logic [3:0] vld;
      logic [7:0] tm0;
      logic       ordy;
      logic [3:0] ir;
      logic       ov;
      int         pid;
      logic [3:0] tm;
      logic       sop;
      logic       eop;
   } vec_t;

   vec_t tbl[14];
   int   cnt0, cnt2, base_stall, pend_ir;

   initial begin
      // vld, tm0, ordy | in_ready, out_valid, pid, tmask, sop, eop (outputs visible during the row)
      tbl[0]  = '{4'h1, 8'hF3, 1'b1, 4'h0, 1'b0, 0, 4'h0, 1'b0, 1'b0};
      tbl[1]  = '{4'h1, 8'hF3, 1'b1, 4'h1, 1'b1, 0, 4'h3, 1'b1, 1'b0};
      tbl[2]  = '{4'h0, 8'hF3, 1'b1, 4'h0, 1'b1, 1, 4'hF, 1'b0, 1'b1};
      tbl[3]  = '{4'h1, 8'hF0, 1'b1, 4'h1, 1'b0, 0, 4'h0, 1'b0, 1'b0};
      tbl[4]  = '{4'h1, 8'h00, 1'b1, 4'h1, 1'b1, 1, 4'hF, 1'b1, 1'b1};
      tbl[5]  = '{4'h0, 8'h00, 1'b1, 4'h0, 1'b1, 0, 4'h0, 1'b1, 1'b1};
      tbl[6]  = '{4'h0, 8'h00, 1'b1, 4'h0, 1'b0, 0, 4'h0, 1'b0, 1'b0};
      tbl[7]  = '{4'h1, 8'hFF, 1'b1, 4'h0, 1'b0, 0, 4'h0, 1'b0, 1'b0};
      tbl[8]  = '{4'h1, 8'hFF, 1'b0, 4'h0, 1'b1, 0, 4'hF, 1'b1, 1'b0};
      tbl[9]  = '{4'h1, 8'hFF, 1'b0, 4'h0, 1'b1, 0, 4'hF, 1'b1, 1'b0};
      tbl[10] = '{4'h1, 8'hFF, 1'b0, 4'h0, 1'b1, 0, 4'hF, 1'b1, 1'b0};
      tbl[11] = '{4'h1, 8'hFF, 1'b1, 4'h1, 1'b1, 0, 4'hF, 1'b1, 1'b0};
      tbl[12] = '{4'h0, 8'hFF, 1'b1, 4'h0, 1'b1, 1, 4'hF, 1'b0, 1'b1};
      tbl[13] = '{4'h0, 8'hFF, 1'b1, 4'h0, 1'b0, 0, 4'h0, 1'b0, 1'b0};

      for (int s = 0; s < IW; s++) begin
         in_header[s*HW +: HW] = hdr_of(s);
         for (int t = 0; t < NT; t++) begin
            in_rs1_data[(s*NT + t)*XL +: XL] = dat(1, s, t);
            in_rs2_data[(s*NT + t)*XL +: XL] = dat(2, s, t);
            in_rs3_data[(s*NT + t)*XL +: XL] = dat(3, s, t);
         end
      end
      in_valid  = '0;
      in_tmask  = '0;
      out_ready = 1'b1;
      reset     = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_stall", 128'(stall_count), 128'(0));
      chk("rst_data", 128'({out_tmask, out_pid, out_sop, out_eop, out_isw}), 128'(0));
      reset = 1'b1;

      // Streams 0 and 2, four full-mask instructions each, back to back.
      @(posedge clk); #1;
      in_valid = 4'b0101;
      in_tmask = {8'h00, 8'hFF, 8'h00, 8'hFF};
      cnt0 = 0; cnt2 = 0;
      @(posedge clk); #1;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         chk_pkt(((n / 2) % 2 == 1) ? 2 : 0, n % 2, 4'hF, (n % 2) == 0, (n % 2) == 1);
         pend_ir = ((n + 1) % 2 == 1 && n + 1 < 16) ? ((((n + 1) / 2) % 2 == 1) ? 4 : 1) : 0;
         chk("rr_in_ready", 128'(in_ready), 128'(pend_ir));
         @(posedge clk); #1;
         if (pend_ir == 1) begin cnt0++; if (cnt0 == 4) in_valid[0] = 1'b0; end
         if (pend_ir == 4) begin cnt2++; if (cnt2 == 4) in_valid[2] = 1'b0; end
      end
      @(negedge clk);
      chk("rr_drained", 128'(out_valid), 128'(0));

      base_stall = int'(stall_count);
      @(posedge clk); #1;
      for (int i = 0; i < 14; i++) begin
         in_valid       = tbl[i].vld;
         in_tmask[7:0]  = tbl[i].tm0;
         out_ready      = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].ir));
         if (tbl[i].ov)
            chk_pkt(0, tbl[i].pid, tbl[i].tm, tbl[i].sop, tbl[i].eop);
         else
            chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(0));
         @(posedge clk); #1;
      end
      chk("stall_delta", 128'(stall_count), 128'(base_stall + 3));

      // Reset landing right after pid0 of a two-batch instruction.
      in_valid = 4'h1;
      in_tmask[7:0] = 8'hFF;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk_pkt(0, 0, 4'hF, 1'b1, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_stall", 128'(stall_count), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
      chk("mid_rst_data", 128'({out_tmask, out_pid, out_sop, out_isw}), 128'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_pkt(0, 0, 4'hF, 1'b1, 1'b0);
      chk("resend_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      in_valid = '0;
      @(negedge clk);
      chk_pkt(0, 1, 4'hF, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
